// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU / octal-Gray / scanned 7-segment display path.
// Operation and FSM state encodings, display-mode constants, the segment lookup
// table and the digit-count helper live here.
package alu_disp_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SHOW = 2'd2
   } state_t;

   localparam logic MODE_OCT  = 1'b0;
   localparam logic MODE_GRAY = 1'b1;

   // Active-high segments, bit0=a ... bit6=g; entry n is the glyph for octal digit n.
   localparam logic [7:0][6:0] SEG_LUT = {
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Number of octal digits needed to show an n-bit value.
   function automatic int ceil_div3(input int n);
      return (n + 2) / 3;
   endfunction

endpackage

// File: rtl/alu_disp_scan_if.sv
// Operand request / result / display bus of alu_disp_scan.
// Handshake: a request is accepted at a rising edge where Valid_in and Ready_out
// are both high; Ready_out is high in IDLE and SHOW and low only during the
// single CALC cycle, and operands/selects are only sampled at that accept edge.
// state_dbg exposes the FSM state for checkers and is not part of the board pinout.
interface alu_disp_scan_if #(
   parameter int WIDTH = 3
);
   localparam int RW     = WIDTH + 1;
   localparam int DIGITS = alu_disp_pkg::ceil_div3(RW);

   logic                      Valid_in;
   logic                      Ready_out;
   logic [WIDTH-1:0]          Num_A_in;
   logic [WIDTH-1:0]          Num_B_in;
   logic [1:0]                Sel_A_in;
   logic                      Sel_M_in;
   logic [RW-1:0]             Result_out;
   logic                      Done_out;
   logic [6:0]                Seg_out;
   logic [DIGITS-1:0]         Dig_en_out;
   logic                      Disp_on_out;
   alu_disp_pkg::state_t      state_dbg;

   // Requester side (switches / test driver).
   modport master (
      output Valid_in, Num_A_in, Num_B_in, Sel_A_in, Sel_M_in,
      input  Ready_out, Result_out, Done_out, Seg_out, Dig_en_out, Disp_on_out, state_dbg
   );

   // Block side.
   modport slave (
      input  Valid_in, Num_A_in, Num_B_in, Sel_A_in, Sel_M_in,
      output Ready_out, Result_out, Done_out, Seg_out, Dig_en_out, Disp_on_out, state_dbg
   );

endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment driver. Latches a display value on restart, then
// steps through the octal digits, holding each one for SCAN_DIV cycles.
// Segments and digit enables are registered together so they never disagree.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is
// always shown).
module seg7_scan
   import alu_disp_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  restart,
   input  logic                  en,
   input  logic [3*DIGITS-1:0]   value,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_en
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [3*DIGITS-1:0]   val_q, val_d;
   logic [6:0]            seg_d;
   logic [DIGITS-1:0]     dig_d;
   logic [2:0]            digit;
   logic                  blank;
`ifdef LEADING_ZERO_BLANK_EN
   logic                  any_nz;
`endif

   // Next scan position, latched value and the glyph for the digit about to be lit.
   always_comb begin
      val_d = val_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      digit = 3'd0;
      blank = 1'b0;
      seg_d = 7'h00;
      dig_d = '0;
`ifdef LEADING_ZERO_BLANK_EN
      any_nz = 1'b0;
`endif
      if (restart) begin
         val_d = value;
         cnt_d = '0;
         idx_d = '0;
      end else if (en) begin
         if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
         idx_d = '0;
      end

      for (int i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_d) digit = val_d[3*i +: 3];
      end

`ifdef LEADING_ZERO_BLANK_EN
      // A digit is a leading zero when it and every higher digit are zero.
      for (int i = 0; i < DIGITS; i++) begin
         if ((IW'(i) >= idx_d) && (val_d[3*i +: 3] != 3'd0)) any_nz = 1'b1;
      end
      blank = (idx_d != '0) && !any_nz;
`else
      blank = 1'b0;
`endif

      if (restart || en) begin
         seg_d = blank ? 7'h00 : SEG_LUT[digit];
         dig_d = DIGITS'(1) << idx_d;
      end
   end

   // Scan state and registered display outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         val_q  <= '0;
         seg    <= 7'h00;
         dig_en <= '0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         val_q  <= val_d;
         seg    <= seg_d;
         dig_en <= dig_d;
      end
   end

endmodule

// File: rtl/alu_disp_scan.sv
// Registered ALU with octal / Gray-octal scanned 7-segment display.
// IDLE waits for a request, CALC registers the result for one cycle, SHOW scans
// the display and accepts further requests. Optional macro LEADING_ZERO_BLANK_EN
// (handled in seg7_scan) blanks leading zero digits.
module alu_disp_scan
   import alu_disp_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic            CLK_in,
   input  logic            RST_n_in,
   alu_disp_scan_if.slave  bus
);

   localparam int RW     = WIDTH + 1;
   localparam int DIGITS = ceil_div3(RW);
   localparam int DW     = 3 * DIGITS;

   state_t            state_q, state_d;
   logic              ready, disp_on, accept;
   logic [WIDTH-1:0]  a_q, b_q;
   op_t               op_q;
   logic              mode_q;
   logic [RW-1:0]     result_q;
   logic              done_q;
   logic [RW-1:0]     a_ext, b_ext, alu_r, gray_r, show_r;
   logic [DW-1:0]     disp_val;

   assign accept = bus.Valid_in && ready;

   // FSM state register.
   always_ff @(posedge CLK_in) begin
      if (!RST_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // FSM next state and handshake/status outputs.
   always_comb begin
      state_d = state_q;
      ready   = 1'b1;
      disp_on = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Valid_in) state_d = CALC;
         end
         CALC: begin
            ready   = 1'b0;
            state_d = SHOW;
         end
         SHOW: begin
            disp_on = 1'b1;
            if (bus.Valid_in) state_d = CALC;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands, operation and mode are captured only at accept.
   always_ff @(posedge CLK_in) begin
      if (!RST_n_in) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         mode_q <= MODE_OCT;
      end else if (accept) begin
         a_q    <= bus.Num_A_in;
         b_q    <= bus.Num_B_in;
         op_q   <= op_t'(bus.Sel_A_in);
         mode_q <= bus.Sel_M_in;
      end
   end

   // ALU on zero-extended operands; add keeps the carry, sub wraps to RW bits.
   always_comb begin
      a_ext = {1'b0, a_q};
      b_ext = {1'b0, b_q};
      alu_r = '0;
      case (op_q)
         OP_ADD:  alu_r = a_ext + b_ext;
         OP_SUB:  alu_r = a_ext - b_ext;
         OP_AND:  alu_r = a_ext & b_ext;
         OP_OR:   alu_r = a_ext | b_ext;
         default: alu_r = '0;
      endcase
   end

   // Display value: raw or Gray-coded result, zero-padded to whole octal digits.
   always_comb begin
      gray_r   = alu_r ^ (alu_r >> 1);
      show_r   = alu_r;
      case (mode_q)
         MODE_OCT:  show_r = alu_r;
         MODE_GRAY: show_r = gray_r;
      endcase
      disp_val         = '0;
      disp_val[RW-1:0] = show_r;
   end

   // Result register and one-cycle done pulse at the end of CALC.
   always_ff @(posedge CLK_in) begin
      if (!RST_n_in) begin
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == CALC);
         if (state_q == CALC) result_q <= alu_r;
      end
   end

   seg7_scan #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk     (CLK_in),
      .rst_n   (RST_n_in),
      .restart (state_q == CALC),
      .en      (state_q == SHOW),
      .value   (disp_val),
      .seg     (bus.Seg_out),
      .dig_en  (bus.Dig_en_out)
   );

   assign bus.Ready_out   = ready;
   assign bus.Disp_on_out = disp_on;
   assign bus.Result_out  = result_q;
   assign bus.Done_out    = done_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: doc/alu_disp_scan.md
Name: alu_disp_scan

Overview:
- Parametrised, registered successor of the 3-bit ALU/octal/Gray display path.
- Accepts WIDTH-bit operands with a valid/ready handshake and computes a (WIDTH+1)-bit result.
- Converts the result to octal digits, either binary-coded or Gray-coded.
- Time-multiplexes the digits onto one 7-segment bus with one-hot digit enables.
- Sits between the operand switches and the board's multiplexed display.

Parameters:
- WIDTH, 3, operand width in bits (>=2).
- SCAN_DIV, 1000, clock cycles each digit stays lit (>=2).
- Localparam RW = WIDTH+1, result width.
- Localparam DIGITS = ceil(RW/3), number of octal digits.

Ports:
- CLK_in  in  1  system clock.
- RST_n_in  in  1  synchronous active-low reset.
- Valid_in  in  1  operand request.
- Ready_out  out  1  block can accept a request.
- Num_A_in  in  WIDTH  operand A.
- Num_B_in  in  WIDTH  operand B.
- Sel_A_in  in  2  operation select: 00 add, 01 sub (A-B), 10 AND, 11 OR.
- Sel_M_in  in  1  display mode: 0 octal of result, 1 octal of Gray(result).
- Result_out  out  RW  registered raw ALU result.
- Done_out  out  1  one-cycle pulse when Result_out updates.
- Seg_out  out  7  active-high segments, bit0=a ... bit6=g.
- Dig_en_out  out  DIGITS  one-hot active-high digit enable; bit0 is the least-significant digit.
- Disp_on_out  out  1  high while in SHOW.

Behaviour:
- Reset (RST_n_in low at a rising edge, any state):
  - state=IDLE; all outputs 0 except Ready_out=1.
  - Scan counter and digit index cleared.
- FSM state IDLE:
  - Ready_out=1; display blank (Seg_out=0, Dig_en_out=0).
  - Valid_in=1 at an edge latches A, B, Sel_A, Sel_M and moves to CALC.
- FSM state CALC (exactly 1 cycle):
  - Ready_out=0; inputs are ignored.
  - At the next edge: Result_out is registered, Done_out pulses for 1 cycle, and the next state is SHOW.
  - Scan counter and digit index reset to 0 on entry to SHOW.
- FSM state SHOW:
  - Ready_out=1; Disp_on_out=1.
  - Valid_in=1 re-latches inputs and moves to CALC. The display holds the old value through CALC, then restarts scanning at digit 0.
- Latency: handshake accepted at edge k → Result_out and Done_out valid after edge k+1.
- Arithmetic:
  - Operands are zero-extended to RW bits.
  - Add: the carry is the MSB.
  - Sub: RW-bit two's complement (2-5 → 4'b1101).
  - AND/OR: MSB = 0.
- Gray: G = R ^ (R>>1), computed on the full RW bits.
- Digit split:
  - The display value is zero-padded to 3*DIGITS bits.
  - Digit i = bits [3i+2:3i].
- Segment codes (hex): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07.
- Scan timing:
  - Counter runs 0..SCAN_DIV-1.
  - At the terminal count, the digit index advances and wraps DIGITS-1 → 0.
  - Dig_en_out = 1<<index; Seg_out is the code of that digit.
- Seg_out and Dig_en_out are registered and change in the same cycle (no ghosting).
- Mode and operation are sampled only at accept. Later changes to Sel_* have no effect until the next accept.
- Valid_in held high in SHOW causes a re-accept every 2 cycles (CALC, SHOW, CALC, ...). This is legal.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, any digit whose value and all higher digits are 0 drives Seg_out=0. Dig_en_out still scans. Digit 0 is never blanked, so value 0 shows "0".
- Undefined: all digits are always displayed, including leading zeros.

Decomposition:
- Package alu_disp_pkg holds:
  - op enum: OP_ADD, OP_SUB, OP_AND, OP_OR;
  - state enum: IDLE, CALC, SHOW;
  - mode constants: MODE_OCT, MODE_GRAY;
  - 8-entry 7-segment lookup constant;
  - function ceil_div3.
- Sub-module seg7_scan (parameters DIGITS, SCAN_DIV) owns the scan counter, digit index, segment lookup and blanking. The top-level holds the FSM, ALU and Gray conversion.

Test Plan:
All scenarios use WIDTH=3 and SCAN_DIV=4.
1. Reset with Valid_in=1 → Ready_out=1, Seg_out=0, Dig_en_out=0, Result_out=0; no accept during reset.
2. A=5, B=6, add, mode 0 → Done_out one cycle after accept, Result_out=11. Display alternates every 4 cycles: Dig_en=01/Seg=4F ('3') and Dig_en=10/Seg=06 ('1').
3. A=5, B=6, add, mode 1 → Gray=14 = octal 16. Digit0 Seg=7D, digit1 Seg=06.
4. A=2, B=5, sub, mode 0 → Result_out=13 = octal 15. Digit0 Seg=6D, digit1 Seg=06.
5. A=3, B=1, AND, mode 0 → Result_out=1. With LEADING_ZERO_BLANK_EN, digit1 Seg=00; without it, Seg=3F.
6. New request mid-scan at digit 1, then RST_n_in low mid-SHOW:
   - New request → CALC for 1 cycle, then scanning restarts at Dig_en=01.
   - Reset → IDLE next cycle with the display blank.
